// File: rtl/imem_fetch_ctrl_pkg.sv
// fetch_pkg: shared state encodings, defaults and PC check
// for the imem_fetch_ctrl instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000D;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  function automatic logic pc_legal(
    input logic [31:0] pc,
    input int unsigned words
  );
    logic [31:0] lim;
    lim = 32'(words) << 2;
    return (pc[1:0] == 2'b00) && (pc < lim);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: one-entry instruction slot handed
// from fetch (master) to decode (slave) via valid/ready.
interface imem_fetch_ctrl_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/imem_fetch_ctrl_perf.sv
// fetch_perf_counters: saturating fetched/stall counters,
// only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Increment each counter, sticking at all-ones.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (fetch_inc && fetched_q != '1)
      fetched_d = fetched_q + 32'd1;
    if (stall_inc && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch sequencer feeding a
// one-entry slot. Optional macro: FETCH_PERF_EN (perf ports).
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned IMEM_WORDS = 32,
  parameter logic [31:0] HALT_WORD  = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  imem_fetch_ctrl_if.master dec,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        halted,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  out_q, out_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         slot_free;

  assign slot_free = !valid_q || dec.instr_ready;

  // Next-state: redirect beats everything, then the
  // fault/halt/load/drain/stall chain on a free slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid)
          pc_d = redirect_pc;
        if (fetch_en)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          if (!pc_legal(redirect_pc, IMEM_WORDS))
            state_d = ST_FAULT;
        end else if (slot_free && fetch_en) begin
          if (!pc_legal(pc_q, IMEM_WORDS)) begin
            state_d = ST_FAULT;
            valid_d = 1'b0;
          end else if (imem_rdata == HALT_WORD) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
          end else begin
            out_d   = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end else if (slot_free) begin
          valid_d = 1'b0;
        end
      end
      ST_HALT: ;
      ST_FAULT: ;
    endcase
  end

  // State, PC and output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_addr       = pc_q;
  assign dec.instr_valid = valid_q;
  assign dec.instr_out   = out_q;
  assign dec.instr_pc    = ipc_q;
  assign halted          = (state_q == ST_HALT);
  assign fault           = (state_q == ST_FAULT);

`ifdef FETCH_PERF_EN
  logic load_w;
  logic stall_w;

  assign load_w = (state_q == ST_RUN)
               && !redirect_valid
               && slot_free && fetch_en
               && pc_legal(pc_q, IMEM_WORDS)
               && (imem_rdata != HALT_WORD);

  assign stall_w = (state_q == ST_RUN)
                && !redirect_valid
                && valid_q && !dec.instr_ready;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_inc    (load_w),
    .stall_inc    (stall_w),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed bench for imem_fetch_ctrl
// with a 32-word combinational memory model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [0:31];

  int checks;
  int failures;

  imem_fetch_ctrl_if dif ();

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec            (dif),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .halted         (halted),
    .fault          (fault)
  );

  assign imem_rdata = (imem_addr < 32'd128)
                    ? mem[imem_addr[6:2]]
                    : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++)
      mem[i] = 32'h2000_0000 + 32'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dif.instr_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fill_linear();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dif.instr_ready = 1'b1;
    step();
    checks++;
    if (dif.instr_valid !== 1'b0 || halted !== 1'b0
        || fault !== 1'b0 || imem_addr !== 32'h0
        || dif.instr_out !== 32'h0
        || dif.instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset v=%b h=%b f=%b a=%h o=%h p=%h",
               dif.instr_valid, halted, fault, imem_addr,
               dif.instr_out, dif.instr_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 0 || perf_stall !== 0) begin
      failures++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0",
               perf_fetched, perf_stall);
    end
`endif
    rst_n = 1'b1;
    step();
    checks++;
    if (dif.instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL idle_hold v=%b a=%h exp v=0 a=0",
               dif.instr_valid, imem_addr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_w [0:2];
    fill_linear();
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_000D;
    exp_w[0] = 32'h2008_0001;
    exp_w[1] = 32'h2009_0002;
    exp_w[2] = 32'h0109_5020;
    do_reset();
    fetch_en = 1'b1;
    step();
    checks++;
    if (dif.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_entry_valid got=%b exp=0",
               dif.instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dif.instr_valid !== 1'b1
          || dif.instr_pc !== 32'(k * 4)
          || dif.instr_out !== exp_w[k]) begin
        failures++;
        $display("FAIL halt_seq%0d v=%b pc=%h o=%h exp pc=%h o=%h",
                 k, dif.instr_valid, dif.instr_pc,
                 dif.instr_out, 32'(k * 4), exp_w[k]);
      end
    end
    step();
    checks++;
    if (halted !== 1'b1 || dif.instr_valid !== 1'b0
        || imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL halt_enter h=%b v=%b a=%h exp 1/0/c",
               halted, dif.instr_valid, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || dif.instr_valid !== 1'b0
        || imem_addr !== 32'hC || fault !== 1'b0) begin
      failures++;
      $display("FAIL halt_sticky h=%b v=%b a=%h f=%b",
               halted, dif.instr_valid, imem_addr, fault);
    end
  endtask

  task automatic test_stall();
    fill_linear();
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    dif.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dif.instr_valid !== 1'b1
          || dif.instr_out !== 32'h2000_0000
          || dif.instr_pc !== 32'h0
          || imem_addr !== 32'h4) begin
        failures++;
        $display("FAIL stall%0d v=%b o=%h p=%h a=%h",
                 k, dif.instr_valid, dif.instr_out,
                 dif.instr_pc, imem_addr);
      end
    end
    dif.instr_ready = 1'b1;
    step();
    checks++;
    if (dif.instr_valid !== 1'b1 || dif.instr_pc !== 32'h4
        || dif.instr_out !== 32'h2000_0001
        || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL stall_release p=%h o=%h a=%h exp 4/20000001/8",
               dif.instr_pc, dif.instr_out, imem_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall !== 32'd3 || perf_fetched !== 32'd2) begin
      failures++;
      $display("FAIL perf got=%0d/%0d exp=3/2",
               perf_stall, perf_fetched);
    end
`endif
    fetch_en = 1'b0;
    step();
    checks++;
    if (dif.instr_valid !== 1'b0 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL drain v=%b a=%h exp 0/8",
               dif.instr_valid, imem_addr);
    end
  endtask

  task automatic test_redirect();
    fill_linear();
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    step();
    checks++;
    if (dif.instr_valid !== 1'b1 || dif.instr_pc !== 32'h4) begin
      failures++;
      $display("FAIL pre_redir v=%b p=%h exp 1/4",
               dif.instr_valid, dif.instr_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (dif.instr_valid !== 1'b0 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL redir_bubble v=%b a=%h exp 0/10",
               dif.instr_valid, imem_addr);
    end
    step();
    checks++;
    if (dif.instr_valid !== 1'b1 || dif.instr_pc !== 32'h10
        || dif.instr_out !== 32'h2000_0004) begin
      failures++;
      $display("FAIL redir_target v=%b p=%h o=%h exp 1/10/20000004",
               dif.instr_valid, dif.instr_pc, dif.instr_out);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h82;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || dif.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_fault f=%b v=%b exp 1/0",
               fault, dif.instr_valid);
    end
    fetch_en = 1'b0;
    step();
    fetch_en = 1'b1;
    step();
    step();
    checks++;
    if (fault !== 1'b1 || dif.instr_valid !== 1'b0
        || halted !== 1'b0 || imem_addr !== 32'h82) begin
      failures++;
      $display("FAIL fault_sticky f=%b v=%b h=%b a=%h",
               fault, dif.instr_valid, halted, imem_addr);
    end
  endtask

  task automatic test_idle_redirect();
    fill_linear();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h8 || dif.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_redir a=%h v=%b exp 8/0",
               imem_addr, dif.instr_valid);
    end
    fetch_en = 1'b1;
    step();
    step();
    checks++;
    if (dif.instr_valid !== 1'b1 || dif.instr_pc !== 32'h8
        || dif.instr_out !== 32'h2000_0002) begin
      failures++;
      $display("FAIL idle_redir_fetch p=%h o=%h exp 8/20000002",
               dif.instr_pc, dif.instr_out);
    end
  endtask

  task automatic test_range_end();
    int bad;
    bad = 0;
    fill_linear();
    do_reset();
    fetch_en = 1'b1;
    step();
    for (int k = 0; k < 32; k++) begin
      step();
      checks++;
      if (dif.instr_valid !== 1'b1
          || dif.instr_pc !== 32'(k * 4)) begin
        failures++;
        bad++;
        if (bad < 4)
          $display("FAIL seq%0d v=%b p=%h exp 1/%h",
                   k, dif.instr_valid, dif.instr_pc,
                   32'(k * 4));
      end
    end
    step();
    checks++;
    if (fault !== 1'b1 || dif.instr_valid !== 1'b0
        || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL range_fault f=%b v=%b a=%h exp 1/0/80",
               fault, dif.instr_valid, imem_addr);
    end
  endtask

  task automatic test_mid_reset();
    fill_linear();
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dif.instr_valid !== 1'b0 || imem_addr !== 32'h0
        || dif.instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_rst v=%b a=%h p=%h exp 0/0/0",
               dif.instr_valid, imem_addr, dif.instr_pc);
    end
    fetch_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (dif.instr_valid !== 1'b0 || imem_addr !== 32'h0
        || fault !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_idle v=%b a=%h f=%b h=%b",
               dif.instr_valid, imem_addr, fault, halted);
    end
    fetch_en = 1'b1;
    step();
    step();
    checks++;
    if (dif.instr_valid !== 1'b1 || dif.instr_pc !== 32'h0
        || dif.instr_out !== 32'h2000_0000) begin
      failures++;
      $display("FAIL post_rst_fetch v=%b p=%h o=%h",
               dif.instr_valid, dif.instr_pc, dif.instr_out);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_halt();
    test_stall();
    test_redirect();
    test_idle_redirect();
    test_range_end();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
